// File: rtl/trace_pkg.sv
// trace_pkg: record kinds and record layout shared by the commit trace buffer.
package trace_pkg;
  localparam int TRACE_DATA_W = 32;
  localparam int TRACE_ADDR_W = 9;
  localparam int SEQ_W = 16;
  typedef enum logic [1:0] {
    REG    = 2'b01,
    MEM_RD = 2'b10,
    MEM_WR = 2'b11
  } trace_kind_e;
  typedef struct packed {
    trace_kind_e kind;
    logic [SEQ_W-1:0] seq;
    logic [TRACE_ADDR_W-1:0] tag;
    logic [TRACE_DATA_W-1:0] data;
  } trace_rec_t;
endpackage

// File: rtl/trace_fifo2w.sv
// trace_fifo2w: FIFO with two in-order write ports and one first-word fall-through read port.
module trace_fifo2w #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push0,
  input  logic [W-1:0]  din0,
  input  logic          push1,
  input  logic [W-1:0]  din1,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (push0) mem[wp] <= din0;
    if (push1) mem[wp + AW'(1)] <= din1;
  end
  // occupancy lives only in count; pointers simply wrap modulo DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push0) + AW'(push1);
      rp <= rp + AW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end
  assign dout = mem[rp];
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: packs core writeback and memory events into sequence-numbered records
// and buffers them for a valid/ready consumer, counting drops instead of stalling the core.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              reg_write_sig,
  input  logic [4:0]        reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [15:0]       out_seq,
  output logic [ADDR_W-1:0] out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic [15:0]       drop_cnt,
  output logic              overflow
);
  localparam int RW = 2 + 16 + ADDR_W + DATA_W;
  logic reg_ev, mem_ev, push0, push1, pop;
  logic [1:0] n_ev, drops;
  logic [CW:0] free;
  logic [15:0] seq;
  logic [16:0] drop_sum;
  logic [RW-1:0] reg_rec, mem_rec, rec0, head;
  trace_kind_e mem_kind;
  assign reg_ev = trace_en & reg_write_sig & (reg_num != 5'd0);
  assign mem_ev = trace_en & (wr | rd);
  assign mem_kind = wr ? MEM_WR : MEM_RD;
  assign reg_rec = {REG, seq, ADDR_W'(reg_num), reg_data};
  // the register write belongs to the older instruction, so MEM takes the next seq
  assign mem_rec = {mem_kind, reg_ev ? seq + 16'd1 : seq, addr, wr ? wr_data : rd_data};
  assign rec0 = reg_ev ? reg_rec : mem_rec;
  assign n_ev = {1'b0, reg_ev} + {1'b0, mem_ev};
  assign out_valid = count != '0;
  assign pop = out_valid & out_ready;
  assign free = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
  assign push0 = (n_ev != 2'd0) & (free != '0);
  assign push1 = (n_ev == 2'd2) & (free >= (CW+1)'(2));
  assign drops = n_ev - {1'b0, push0} - {1'b0, push1};
  assign drop_sum = {1'b0, drop_cnt} + 17'(drops);
  always_ff @(posedge clk) begin
    if (reset) begin
      seq <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      seq <= seq + 16'(n_ev);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      overflow <= overflow | (drops != 2'd0);
    end
  end
  trace_fifo2w #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push0(push0),
    .din0(rec0),
    .push1(push1),
    .din1(mem_rec),
    .pop(pop),
    .dout(head),
    .count(count)
  );
  assign out_kind = head[RW-1 -: 2];
  assign out_seq = head[DATA_W+ADDR_W +: 16];
  assign out_tag = head[DATA_W +: ADDR_W];
  assign out_data = head[DATA_W-1:0];
endmodule
